// File: rtl/clkout_div_xilusp_if.sv
// Control/status bundle for the forwarded-clock divider: enable level, ratio
// handshake, and the status the divider reports back.
interface clkout_div_xilusp_if #(
   parameter int unsigned DIV_W = 8
);
   logic             en_i;
   logic [DIV_W-1:0] div_i;
   logic             div_valid_i;
   logic             div_ready_o;
   logic [DIV_W-1:0] div_active_o;
   logic             running_o;
   logic             clk_div_o;

   // Requester side: drives enable and ratio, observes status.
   modport master (
      output en_i, div_i, div_valid_i,
      input  div_ready_o, div_active_o, running_o, clk_div_o
   );

   // Divider side.
   modport slave (
      input  en_i, div_i, div_valid_i,
      output div_ready_o, div_active_o, running_o, clk_div_o
   );
endinterface

// File: rtl/clkout_div_xilusp.sv
// Fabric clock forwarder: divides clk_sys by a runtime ratio N (>= 2) and drives
// the result off-chip differentially. Ratio changes and disables take effect
// only at period boundaries, so the pins never see runt pulses.
module clkout_div_xilusp #(
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned DIV_RESET = 4
) (
   input  logic                clk_sys,
   input  logic                rst_sys,
   clkout_div_xilusp_if.slave  bus,
   output logic                IO_CLKOUT_P,
   output logic                IO_CLKOUT_N
);

   localparam logic [DIV_W-1:0] DivRst = (DIV_RESET < 2) ? DIV_W'(2) : DIV_W'(DIV_RESET);

   typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic [DIV_W-1:0] n_act_q, n_act_d;
   logic [DIV_W-1:0] n_pend_q, n_pend_d;
   logic             pend_full_q, pend_full_d;

   logic             wrap;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W:0]   half;
   logic [DIV_W-1:0] div_clamped;

   // Last count of the period; never true in idle because cnt is 0 and N >= 2.
   assign wrap        = (cnt_q == (n_act_q - DIV_W'(1)));
   assign cnt_nxt     = wrap ? '0 : (cnt_q + DIV_W'(1));
   // High phase is ceil(N/2); one extra bit so N = 2^DIV_W - 1 cannot overflow.
   assign half        = ({1'b0, n_act_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
   assign div_clamped = (bus.div_i < DIV_W'(2)) ? DIV_W'(2) : bus.div_i;

   // State register.
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Next state: a disable only lands in idle at a wrap edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (bus.en_i) state_d = StRun;
         StRun:      if (!bus.en_i) state_d = wrap ? StIdle : StStopping;
         StStopping: begin
            if (bus.en_i)  state_d = StRun;
            else if (wrap) state_d = StIdle;
         end
         default:    state_d = StIdle;
      endcase
   end

   // Counter, divided clock and ratio slot next values.
   always_comb begin
      cnt_d       = cnt_q;
      clk_d       = clk_q;
      n_act_d     = n_act_q;
      n_pend_d    = n_pend_q;
      pend_full_d = pend_full_q;

      if (state_d == StIdle) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (state_q == StIdle) begin
         cnt_d = '0;
         clk_d = 1'b1;
      end else begin
         cnt_d = cnt_nxt;
         clk_d = ({1'b0, cnt_nxt} < half);
      end

      // Apply only from a full slot and capture only into an empty one, so the
      // two can never coincide on one edge.
      if (pend_full_q && ((state_q == StIdle) || wrap)) begin
         n_act_d     = n_pend_q;
         pend_full_d = 1'b0;
      end else if (bus.div_valid_i && !pend_full_q) begin
         n_pend_d    = div_clamped;
         pend_full_d = 1'b1;
      end
   end

   // Datapath registers; reset drops the pins and any queued ratio at once.
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         cnt_q       <= '0;
         clk_q       <= 1'b0;
         n_act_q     <= DivRst;
         n_pend_q    <= DivRst;
         pend_full_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         clk_q       <= clk_d;
         n_act_q     <= n_act_d;
         n_pend_q    <= n_pend_d;
         pend_full_q <= pend_full_d;
      end
   end

   // Status outputs decoded from registered state.
   always_comb begin
      bus.running_o    = (state_q != StIdle);
      bus.div_ready_o  = !pend_full_q;
      bus.div_active_o = n_act_q;
      bus.clk_div_o    = clk_q;
   end

   // Behavioural stand-in for the OBUFDS pair: pad delay only, no extra flops.
   assign IO_CLKOUT_P = clk_q;
   assign IO_CLKOUT_N = ~clk_q;

endmodule

// File: tb/tb_clkout_div_xilusp.sv
// Bench for clkout_div_xilusp: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a period-level waveform model.
module tb_clkout_div_xilusp;

   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic io_p, io_n;

   clkout_div_xilusp_if #(.DIV_W(DW)) bus ();

   clkout_div_xilusp #(.DIV_W(DW), .DIV_RESET(4)) dut (
      .clk_sys     (clk),
      .rst_sys     (rst),
      .bus         (bus),
      .IO_CLKOUT_P (io_p),
      .IO_CLKOUT_N (io_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Model: whole periods are queued as waveforms; the enable only matters when
   // a period has been fully emitted.
   bit m_run;
   bit m_clk;
   int m_n;
   int m_pend[$];
   bit m_per[$];

   task automatic model_reset();
      m_run = 0;
      m_clk = 0;
      m_n   = 4;
      m_pend.delete();
      m_per.delete();
   endtask

   task automatic load_period();
      m_per.delete();
      for (int i = 0; i < m_n; i++) m_per.push_back(i < (m_n + 1) / 2);
   endtask

   task automatic model_step(input bit en, input bit vld, input int d);
      bit ready_pre;
      int dc;
      ready_pre = (m_pend.size() == 0);
      dc        = (d < 2) ? 2 : d;
      if (!m_run || m_per.size() == 0) begin
         // Idle edge or period boundary.
         if (!ready_pre) m_n = m_pend.pop_front();
         else if (vld)   m_pend.push_back(dc);
         if (en) begin
            m_run = 1;
            load_period();
            m_clk = m_per.pop_front();
         end else begin
            m_run = 0;
            m_clk = 0;
         end
      end else begin
         if (ready_pre && vld) m_pend.push_back(dc);
         m_clk = m_per.pop_front();
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, "_clk"},    bus.clk_div_o, m_clk);
      check_eq({tag, "_p"},      io_p, m_clk);
      check_eq({tag, "_n"},      io_n, !m_clk);
      check_eq({tag, "_run"},    bus.running_o, m_run);
      check_eq({tag, "_ready"},  bus.div_ready_o, m_pend.size() == 0);
      check_eq({tag, "_active"}, bus.div_active_o, m_n);
   endtask

   task automatic cycle(input bit en, input bit vld, input int d, input string tag);
      @(negedge clk);
      bus.en_i        = en;
      bus.div_valid_i = vld;
      bus.div_i       = DW'(d);
      @(posedge clk);
      model_step(en, vld, d);
      #1;
      compare_all(tag);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((m_run || m_pend.size() != 0) && g < 600) begin
         cycle(0, 0, 0, "drain");
         g++;
      end
      check_eq("drain_timeout", (g < 600), 1);
   endtask

   task automatic load_ratio(input int n);
      drain();
      cycle(0, 1, n, "load");
      cycle(0, 0, 0, "apply");
   endtask

   task automatic pattern_test(input int n, input string tag);
      bit [15:0] got, exp;
      int nn;
      nn = (n < 2) ? 2 : n;
      load_ratio(n);
      check_eq({tag, "_active"}, bus.div_active_o, nn);
      got = '0;
      exp = '0;
      for (int i = 0; i < 16; i++) begin
         cycle(1, 0, 0, tag);
         got[i] = bus.clk_div_o;
         exp[i] = ((i % nn) < (nn + 1) / 2);
      end
      check_eq({tag, "_pattern"}, got, exp);
   endtask

   initial begin
      bit en_r;
      bus.en_i        = 1'b0;
      bus.div_valid_i = 1'b0;
      bus.div_i       = '0;
      model_reset();

      // Reset held for 3 cycles while the enable toggles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.en_i = (i % 2 == 0);
         @(posedge clk);
         #1;
         compare_all("reset");
      end
      @(negedge clk);
      bus.en_i = 1'b0;
      rst      = 1'b0;

      pattern_test(4, "div4");
      pattern_test(5, "div5");
      pattern_test(2, "div2");
      pattern_test(0, "clamp0");
      pattern_test(1, "clamp1");

      // Mid-run change 4 -> 6, with a second push stalled behind it.
      load_ratio(4);
      cycle(1, 0, 0, "chg");
      cycle(1, 1, 6, "chg");
      check_eq("chg_ready_low", bus.div_ready_o, 0);
      cycle(1, 1, 9, "chg");
      cycle(1, 1, 9, "chg");
      check_eq("chg_stall_active", bus.div_active_o, 4);
      cycle(1, 0, 0, "chg");
      check_eq("chg_wrap_active", bus.div_active_o, 6);
      check_eq("chg_wrap_ready", bus.div_ready_o, 1);
      for (int i = 0; i < 8; i++) cycle(1, 0, 0, "chg");

      // Disable with N=6: period completes, then idle.
      load_ratio(6);
      cycle(1, 0, 0, "dis");
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, "dis");
      check_eq("dis_run_hold", bus.running_o, 1);
      cycle(0, 0, 0, "dis");
      check_eq("dis_run_fall", bus.running_o, 0);
      check_eq("dis_clk_low", bus.clk_div_o, 0);

      // Re-enable before the wrap: no interruption.
      cycle(1, 0, 0, "reen");
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, "reen");
      for (int i = 0; i < 6; i++) cycle(1, 0, 0, "reen");
      check_eq("reen_running", bus.running_o, 1);

      // Randomized traffic.
      en_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         int d;
         bit v;
         if ($urandom_range(0, 19) == 0) en_r = !en_r;
         v = ($urandom_range(0, 3) == 0);
         d = ($urandom_range(0, 30) == 0) ? int'($urandom_range(10, 40))
                                          : int'($urandom_range(0, 9));
         cycle(en_r, v, d, "rand");
      end

      // Async reset mid-high-phase with a ratio pending.
      load_ratio(4);
      cycle(1, 0, 0, "arst");
      cycle(1, 1, 7, "arst");
      check_eq("arst_pending", bus.div_ready_o, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("arst_clk", bus.clk_div_o, 0);
      check_eq("arst_p", io_p, 0);
      check_eq("arst_n", io_n, 1);
      check_eq("arst_ready", bus.div_ready_o, 1);
      check_eq("arst_active", bus.div_active_o, 4);
      check_eq("arst_run", bus.running_o, 0);
      @(negedge clk);
      bus.en_i        = 1'b0;
      bus.div_valid_i = 1'b0;
      rst             = 1'b0;
      cycle(0, 0, 0, "post_arst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clkout_div_xilusp.md
# clkout_div_xilusp

Fabric clock forwarder for Ultrascale+ boards. It divides `clk_sys` by a runtime-programmable integer ratio and drives the result off-chip through an `OBUFDS` differential output buffer. It is the transmit-side counterpart of the differential clock input path and supplies reference or sample clocks to external devices. Divider changes are handshaked and applied only at period boundaries, and disable always completes the current period, so the pins never carry runt pulses.

## Interface

Parameters:
- `DIV_W`, default 8: width of divide-ratio fields.
- `DIV_RESET`, default 4: divide ratio loaded at reset. Clamped to a minimum of 2.

Ports:
- `clk_sys`, in, 1: the only clock.
- `rst_sys`, in, 1: asynchronous, active-high reset.
- `en_i`, in, 1: request clock output (level).
- `div_i`, in, DIV_W: new divide ratio N.
- `div_valid_i`, in, 1: `div_i` valid.
- `div_ready_o`, out, 1: pending-ratio slot empty.
- `div_active_o`, out, DIV_W: ratio currently in use.
- `running_o`, out, 1: state is not IDLE.
- `clk_div_o`, out, 1: registered single-ended divided clock (internal copy).
- `IO_CLKOUT_P`, out, 1: `OBUFDS` true output of `clk_div_o`.
- `IO_CLKOUT_N`, out, 1: `OBUFDS` complement output of `clk_div_o`.

## Operation

- Registers:
  - `cnt` is DIV_W bits.
  - `n_act` is the active ratio N.
  - `n_pend` plus `pend_full` hold a queued ratio.
  - `state` is one of IDLE, RUN, STOPPING.
  - `clk_q` drives `clk_div_o` directly. It is a flop output, with no combinational logic after it.
- Period and duty:
  - Period is N cycles. `cnt` runs 0..N-1 and wraps to 0.
  - `clk_q` = (cnt_next < H), where H = (N+1)>>1, i.e. the high phase takes the ceiling of N/2.
  - Because N ≥ 2, the last count of every period is low.
- Ratio clamp: any accepted `div_i` < 2 is stored as 2. The maximum ratio is 2^DIV_W − 1.
- State IDLE:
  - `cnt`=0 and `clk_q`=0.
  - On `en_i`=1, go to RUN with `cnt`=0 and `clk_q`=1.
- State RUN:
  - Count continuously.
  - On `en_i`=0: if `cnt`==N-1, go to IDLE at that edge. Otherwise go to STOPPING.
- State STOPPING:
  - Keep counting.
  - At the wrap edge (`cnt`==N-1), go to IDLE with `clk_q`=0.
  - If `en_i`=1 is sampled, return to RUN with no change to `cnt` or `clk_q`.
- Ratio handshake:
  - `div_ready_o` = !`pend_full`.
  - A transfer happens on a rising edge where `div_valid_i` and `div_ready_o` are both high. It loads `n_pend` and sets `pend_full`.
  - Applying the pending ratio: in RUN or STOPPING, at the wrap edge, do `n_act`←`n_pend` and clear `pend_full`. In IDLE, apply at the first edge after capture.
  - The new N governs the period starting at the wrap edge.
  - A capture and an application never happen on the same edge: a value captured at a wrap edge waits for the next boundary.
- Reset mid-operation: the pins go low asynchronously, and any pending ratio is discarded.

## Timing

- Reset values:
  - `clk_div_o`=0, so P=0 and N=1.
  - `running_o`=0.
  - `div_ready_o`=1.
  - `div_active_o`=DIV_RESET (clamped).
  - `cnt`=0, state IDLE.
- `en_i` rise sampled at edge t: `clk_div_o` rises at edge t, and `running_o`=1 from edge t.
- `en_i` fall: `clk_div_o` stays low from the end of the current period. `running_o` falls at the wrap edge.
- Ratio latency:
  - When running, the new ratio takes effect at the next wrap edge, up to N cycles later.
  - When idle, it takes effect 1 cycle after capture.
- `div_ready_o` returns to 1 at the application edge, so a new ratio can be accepted the following edge.
- The `OBUFDS` adds pad delay only. No extra flop stages.

## Test plan

- Reset: hold `rst_sys`=1 for 3 cycles, then check:
  - `clk_div_o`=0, `IO_CLKOUT_P`/`IO_CLKOUT_N`=0/1, `running_o`=0, `div_ready_o`=1, `div_active_o`=4.
  - Toggling `en_i` during reset does nothing.
- Divide patterns (`en_i`=1):
  - With N=4, `clk_div_o` repeats 1,1,0,0.
  - After loading N=5, it repeats 1,1,1,0,0.
  - After loading N=2, it repeats 1,0.
- Mid-run ratio change: N=4 running, push `div_i`=6 at `cnt`=1, then check:
  - `div_ready_o` goes to 0.
  - The current period ends as ...,0,0.
  - The next period is 1,1,1,0,0,0.
  - `div_active_o`=6 and `div_ready_o`=1 at the wrap edge.
  - A second push during the wait is stalled.
- Disable and re-enable with N=6:
  - Drop `en_i` at `cnt`=0: the output finishes 1,1,1,0,0,0, then stays low, and `running_o` falls at the wrap edge.
  - Repeat, but reassert `en_i` at `cnt`=3: the pattern is uninterrupted and `running_o` stays 1.
- Clamp: push `div_i`=0 and then `div_i`=1. Each gives `div_active_o`=2 and the pattern 1,0.
- Async reset: assert `rst_sys` mid-high-phase, between clock edges. `clk_div_o` must fall without waiting for an edge, and the pending ratio must be dropped (`div_ready_o`=1, `div_active_o`=4).
